hazard_control_unit: RTL
========================

Name: hazard_control_unit

Overview:
- Pipeline hazard and stall controller for the 5-stage RV32I core.
- Sits in ID, directly upstream of the ID/EX register that feeds the forwarding logic. Generates the write enables and bubble/flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Covers load-use stalls, taken-branch flushes, multicycle EX ops and data-memory wait states, which forwarding cannot resolve.
- Keeps a small FSM, saturating stall/flush performance counters and a sticky data-memory watchdog.

Parameters:
- MEM_TIMEOUT, 256, cycles of continuous MEM_WAIT before mem_timeout is set.
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- id_rs1  in  5  rs1 of instruction in ID
- id_rs2  in  5  rs2 of instruction in ID
- id_uses_rs1  in  1  ID instruction reads rs1
- id_uses_rs2  in  1  ID instruction reads rs2
- id_ex_rd  in  5  rd of instruction in EX
- id_ex_MemRead  in  1  EX instruction is a load
- ex_branch_taken  in  1  branch/jump in EX redirects PC
- ex_mc_start  in  1  multicycle op (mul/div) enters EX this cycle
- ex_mc_done  in  1  multicycle result valid
- mem_req  in  1  MEM stage has an outstanding data access
- mem_ready  in  1  data memory completes the access this cycle
- pc_write  out  1  PC register enable
- if_id_write  out  1  IF/ID register enable
- if_id_flush  out  1  IF/ID loads NOP
- id_ex_write  out  1  ID/EX register enable
- id_ex_flush  out  1  ID/EX loads bubble (all control 0)
- ex_mem_write  out  1  EX/MEM register enable
- ex_mem_flush  out  1  EX/MEM loads bubble
- mem_wb_flush  out  1  MEM/WB loads bubble
- state_o  out  2  current FSM state (debug)
- stall_cycles  out  CNT_W  cycles with pc_write=0
- flush_count  out  CNT_W  taken-branch flush events
- load_use_count  out  CNT_W  load-use stalls
- mem_timeout  out  1  sticky watchdog error

Behaviour:
- Reset:
  - State RUN; all counters 0; mem_timeout 0.
  - While reset is high, outputs take the RUN/no-hazard values: all *_write=1, all *_flush=0.
- FSM states: RUN=0, MC_BUSY=1, MEM_WAIT=2, LOAD_STALL=3.
- Hazard terms:
  - load_use = id_ex_MemRead && id_ex_rd!=0 && ((id_uses_rs1 && id_ex_rd==id_rs1) || (id_uses_rs2 && id_ex_rd==id_rs2)).
  - mem_stall = mem_req && !mem_ready.
- Outputs are combinational from state plus inputs. Priority, highest first:
  1. mem_stall (any state): pc/if_id/id_ex/ex_mem write=0; mem_wb_flush=1; every other flush=0. Next state MEM_WAIT. A branch or load-use at the same time is held, not acted on.
  2. MC_BUSY && !ex_mc_done: pc/if_id/id_ex write=0; ex_mem_flush=1; ex_mem_write=1.
  3. ex_branch_taken: if_id_flush=1; id_ex_flush=1; pc_write=1; flush_count++. A branch wins over a simultaneous load_use, because the ID instruction is squashed.
  4. load_use: pc_write=0; if_id_write=0; id_ex_flush=1; load_use_count++. Next state LOAD_STALL for exactly one cycle, then RUN. Exactly one bubble per load.
  5. Otherwise all write=1, all flush=0.
- Multicycle ops: ex_mc_start in RUN with no higher-priority term moves to MC_BUSY.
  - ex_mc_done in MC_BUSY gives normal flow that cycle, then RUN.
  - start and done in the same cycle: stay RUN.
- Leaving MEM_WAIT: on the first cycle with !mem_stall, evaluate rules 2–5 and go to the matching state.
  - Return to MC_BUSY if MEM_WAIT was entered from MC_BUSY. A 1-bit saved flag records this.
- Counters:
  - stall_cycles increments each cycle pc_write=0.
  - All counters saturate at all-ones and never wrap.
- Watchdog:
  - wait_cnt counts consecutive MEM_WAIT cycles and clears on exit.
  - When wait_cnt reaches MEM_TIMEOUT, mem_timeout is set. It stays set until reset and does not change pipeline control.
- Reset mid-stall: next cycle is RUN with counters at 0. Pending branch/mc state is discarded.

Decomposition:
- Add to common package:
  - hazard_state_t enum (RUN, MC_BUSY, MEM_WAIT, LOAD_STALL).
  - localparam HAZ_CNT_W=32.
- One sub-module: sat_counter (parameter W; ports clk, reset, inc, count). Instantiated three times for the performance counters.

Test Plan:
- Load-use: id_ex_MemRead=1, id_ex_rd=5, id_rs1=5, id_uses_rs1=1 → one cycle of pc_write=0, if_id_write=0, id_ex_flush=1. Next cycle state=LOAD_STALL then RUN; load_use_count=1. Repeat with id_ex_rd=0 → no stall.
- Branch vs load-use: ex_branch_taken=1 together with load_use → if_id_flush=1, id_ex_flush=1, pc_write=1; flush_count=1, load_use_count=0.
- Memory wait: mem_req=1, mem_ready=0 for 4 cycles, then mem_ready=1 → 4 cycles of pc/if_id/id_ex/ex_mem write=0 with mem_wb_flush=1; stall_cycles=4; normal flow on cycle 5.
- Multicycle with mem wait: ex_mc_start, then 3 busy cycles with a 2-cycle mem_stall inserted, then ex_mc_done → states RUN→MC_BUSY→MEM_WAIT×2→MC_BUSY→RUN. ex_mem_flush=1 only in MC_BUSY cycles.
- Watchdog: MEM_TIMEOUT=8, mem_stall held 8 cycles → mem_timeout=1 after the 8th cycle and stays 1 after mem_ready. Reset → mem_timeout=0, state=RUN, counters=0.
- Saturation: CNT_W=4, 20 load-use events → load_use_count=15.

Source files
------------

// File: rtl/hazard_control_unit_pkg.sv
// Shared types for the pipeline hazard controller.
// FSM state encoding and default counter width.
package hazard_control_unit_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        MC_BUSY    = 2'd1,
        MEM_WAIT   = 2'd2,
        LOAD_STALL = 2'd3
    } hazard_state_t;

    localparam int HAZ_CNT_W = 32;

endpackage

// File: rtl/hazard_control_unit_sat_counter.sv
// Saturating up-counter used for the performance counters.
// Holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    // count up on inc, stop at all-ones
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/hazard_control_unit.sv
// Hazard/stall controller for the 5-stage RV32I pipeline.
// Drives stage enables and bubbles; keeps perf counters and a watchdog.
module hazard_control_unit
    import hazard_control_unit_pkg::*;
#(
    parameter int MEM_TIMEOUT = 256,
    parameter int CNT_W       = HAZ_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       id_ex_rd,
    input  logic             id_ex_MemRead,
    input  logic             ex_branch_taken,
    input  logic             ex_mc_start,
    input  logic             ex_mc_done,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_write,
    output logic             id_ex_flush,
    output logic             ex_mem_write,
    output logic             ex_mem_flush,
    output logic             mem_wb_flush,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic [CNT_W-1:0] load_use_count,
    output logic             mem_timeout
);

    localparam int WT_W = $clog2(MEM_TIMEOUT + 1);

    hazard_state_t   state;
    hazard_state_t   state_n;
    logic            mc_saved;
    logic            mc_saved_n;
    logic [WT_W-1:0] wait_cnt;

    logic lu_hit;
    logic load_use;
    logic mem_stall;
    logic mc_mode;
    logic act_mem;
    logic act_mc;
    logic act_br;
    logic act_lu;
    logic act_run;

    // hazard terms and one-hot selection of the winning rule
    always_comb begin
        lu_hit = id_ex_MemRead && (id_ex_rd != 5'd0) &&
                 ((id_uses_rs1 && (id_ex_rd == id_rs1)) ||
                  (id_uses_rs2 && (id_ex_rd == id_rs2)));
        // the bubble is already in EX during LOAD_STALL: one stall per load
        load_use  = lu_hit && (state != LOAD_STALL);
        mem_stall = mem_req && !mem_ready;
        mc_mode   = (state == MC_BUSY) ||
                    ((state == MEM_WAIT) && mc_saved);
        act_mem   = !reset && mem_stall;
        act_mc    = !reset && !mem_stall && mc_mode && !ex_mc_done;
        act_br    = !reset && !mem_stall && !act_mc && ex_branch_taken;
        act_lu    = !reset && !mem_stall && !act_mc &&
                    !ex_branch_taken && load_use;
        act_run   = !(act_mem || act_mc || act_br || act_lu);
    end

    // pipeline controls and next state for the selected rule
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_write  = 1'b1;
        ex_mem_write = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        mem_wb_flush = 1'b0;
        state_n      = RUN;
        mc_saved_n   = 1'b0;
        unique case (1'b1)
            act_mem: begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_write  = 1'b0;
                ex_mem_write = 1'b0;
                mem_wb_flush = 1'b1;
                state_n      = MEM_WAIT;
                mc_saved_n   = (state == MEM_WAIT) ? mc_saved
                                                   : (state == MC_BUSY);
            end
            act_mc: begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_write  = 1'b0;
                ex_mem_flush = 1'b1;
                state_n      = MC_BUSY;
            end
            act_br: begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end
            act_lu: begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                id_ex_flush = 1'b1;
                state_n     = LOAD_STALL;
            end
            act_run: begin
                if (ex_mc_start && !ex_mc_done) begin
                    state_n = MC_BUSY;
                end
            end
            default: begin
                state_n = RUN;
            end
        endcase
    end

    // state register and the came-from-MC_BUSY flag
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= RUN;
            mc_saved <= 1'b0;
        end else begin
            state    <= state_n;
            mc_saved <= mc_saved_n;
        end
    end

    // sticky watchdog over consecutive memory wait cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else if (mem_stall) begin
            if (wait_cnt != WT_W'(MEM_TIMEOUT)) begin
                wait_cnt <= wait_cnt + WT_W'(1);
            end
            if (wait_cnt == WT_W'(MEM_TIMEOUT - 1)) begin
                mem_timeout <= 1'b1;
            end
        end else begin
            wait_cnt <= '0;
        end
    end

    assign state_o = state;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (!pc_write),
        .count (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (act_br),
        .count (flush_count)
    );

    sat_counter #(.W(CNT_W)) u_lu_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (act_lu),
        .count (load_use_count)
    );

endmodule
